multi_debouncer: RTL and testbench

- Parametrised N-channel debouncer for board buttons and game-pad switches; replaces the fixed 8-input debounce wrapper.
- Each channel has:
  - an input synchroniser;
  - a counter-based stability filter;
  - a level output;
  - one-cycle press and release ticks.
- Per-channel polarity inversion is supported.
- Sits between the top-level pins and the game control logic, all in the pclk domain.

---
 rtl/debounce_pkg.sv | 32 +++
 rtl/debounce_channel.sv | 172 +++++++++++++++++
 rtl/multi_debouncer.sv | 53 +++++
 tb/tb_multi_debouncer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and helpers for the multi-channel debouncer.
//               Holds the per-channel FSM state encoding and the counter
//               width helper used to size the stability and repeat counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    // Bits needed to hold the values 0..max_val (never less than one bit)
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One debounce channel: optional input inversion, multi-flop
//               synchroniser, counter-based stability filter FSM, registered
//               level output and one-cycle press/release ticks.
//               Optional feature macro: DEBOUNCE_AUTOREPEAT_EN adds
//               hold-to-repeat press ticks while the channel stays high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 650000,
    parameter int SYNC_STAGES   = 2,
    parameter bit INVERT        = 1'b0,
    parameter int REPEAT_DELAY  = 32500000,
    parameter int REPEAT_PERIOD = 6500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press_tick,
    output logic o_release_tick
);

    localparam int                 c_CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // Parameter sanity checks at elaboration time
    if (STABLE_CYCLES < 1) begin : g_chk_stable
        $error("debounce_channel: STABLE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_t              r_state;
    db_state_t              w_state_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic                   w_press_accept;
    logic                   w_release_accept;
    logic                   w_level_next;
    logic                   w_press_next;
    logic                   r_level;
    logic                   r_press_tick;
    logic                   r_release_tick;

    // Synchronise the polarity-corrected raw input into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw ^ INVERT};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a new level is accepted only after the full stable run
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE_LO: if (w_s) w_state_next = WAIT_HI;
            WAIT_HI: begin
                if (!w_s)                    w_state_next = IDLE_LO;
                else if (r_cnt == c_CNT_MAX) w_state_next = IDLE_HI;
            end
            IDLE_HI: if (!w_s) w_state_next = WAIT_LO;
            WAIT_LO: begin
                if (w_s)                     w_state_next = IDLE_HI;
                else if (r_cnt == c_CNT_MAX) w_state_next = IDLE_LO;
            end
            default: w_state_next = IDLE_LO;
        endcase
    end

    // Output/datapath decode: stability counter, acceptance strobes, level
    always_comb begin
        w_cnt_inc        = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
        w_cnt_next       = '0;
        w_press_accept   = (r_state == WAIT_HI) && (w_state_next == IDLE_HI);
        w_release_accept = (r_state == WAIT_LO) && (w_state_next == IDLE_LO);
        w_level_next     = (w_state_next == IDLE_HI) || (w_state_next == WAIT_LO);
        case (r_state)
            IDLE_LO: if (w_state_next == WAIT_HI) w_cnt_next = c_CNT_ONE;
            WAIT_HI: if (w_state_next == WAIT_HI) w_cnt_next = w_cnt_inc;
            IDLE_HI: if (w_state_next == WAIT_LO) w_cnt_next = c_CNT_ONE;
            WAIT_LO: if (w_state_next == WAIT_LO) w_cnt_next = w_cnt_inc;
            default: w_cnt_next = '0;
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                 c_REP_W      = cnt_width(c_REP_MAX);
    localparam logic [c_REP_W-1:0] c_REP_DELAY  = c_REP_W'(REPEAT_DELAY);
    localparam logic [c_REP_W-1:0] c_REP_PERIOD = c_REP_W'(REPEAT_PERIOD);
    localparam logic [c_REP_W-1:0] c_REP_ONE    = c_REP_W'(1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic [c_REP_W-1:0] w_rep_inc;
    logic               w_rep_hold;
    logic               w_rep_fire;

    // Repeat fires when the hold count reaches the delay, then each period
    always_comb begin
        w_rep_inc  = r_rep_cnt + c_REP_ONE;
        w_rep_hold = (r_state == IDLE_HI) && (w_state_next == IDLE_HI);
        w_rep_fire = w_rep_hold && (w_rep_inc == (r_rep_armed ? c_REP_PERIOD : c_REP_DELAY));
    end

    // Repeat counter restarts on every entry to IDLE_HI and idles elsewhere
    always_ff @(posedge clk) begin
        if (rst || !w_rep_hold) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt   <= w_rep_inc;
        end
    end

    assign w_press_next = w_press_accept | w_rep_fire;
`else
    assign w_press_next = w_press_accept;
`endif

    // Registered counter, level and tick outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_level        <= 1'b0;
            r_press_tick   <= 1'b0;
            r_release_tick <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_level        <= w_level_next;
            r_press_tick   <= w_press_next;
            r_release_tick <= w_release_accept;
        end
    end

    assign o_level        = r_level;
    assign o_press_tick   = r_press_tick;
    assign o_release_tick = r_release_tick;

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module      : multi_debouncer
// Description : Parametrised N-channel debouncer for buttons and switches.
//               Instantiates one independent debounce_channel per input and
//               concatenates their level / press / release outputs.
//               Optional feature macro: DEBOUNCE_AUTOREPEAT_EN (auto-repeat
//               press ticks while a channel is held).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS      = 8,
    parameter int                  STABLE_CYCLES = 650000,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CHANNELS-1:0] INVERT_MASK   = {CHANNELS{1'b0}},
    parameter int                  REPEAT_DELAY  = 32500000,
    parameter int                  REPEAT_PERIOD = 6500000
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_tick,
    output logic [CHANNELS-1:0] release_tick
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_chk_channels
        $error("multi_debouncer: CHANNELS must be in 1..32");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .INVERT        (INVERT_MASK[i]),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk            (pclk),
            .rst            (rst),
            .i_raw          (raw_in[i]),
            .o_level        (level[i]),
            .o_press_tick   (press_tick[i]),
            .o_release_tick (release_tick[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Directed self-checking bench for multi_debouncer with
//               CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2, channel 2
//               inverted, REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations for
//               the auto-repeat scenario follow DEBOUNCE_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_debouncer;

    localparam int c_CH = 4;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit c_AUTOREPEAT = 1'b1;
`else
    localparam bit c_AUTOREPEAT = 1'b0;
`endif

    logic            pclk   = 1'b0;
    logic            rst    = 1'b1;
    logic [c_CH-1:0] raw_in = 4'b0100;
    logic [c_CH-1:0] level;
    logic [c_CH-1:0] press_tick;
    logic [c_CH-1:0] release_tick;

    int n_cmp = 0;
    int n_bad = 0;

    multi_debouncer #(
        .CHANNELS      (c_CH),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .INVERT_MASK   (4'b0100),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .raw_in       (raw_in),
        .level        (level),
        .press_tick   (press_tick),
        .release_tick (release_tick)
    );

    always #5 pclk = ~pclk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Outputs stay cleared while reset is held
    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            got = {level, press_tick, release_tick};
            n_cmp++;
            if (got !== 12'h000) begin
                n_bad++;
                $display("FAIL reset step %0d: got {lvl,prs,rel}=%b expected %b", c, got, 12'h000);
            end
        end
        rst = 1'b0;
    endtask

    // Clean 0->1 step on channel 0, then clean 1->0
    task automatic test_clean_step();
        logic [11:0] got, exp;
        raw_in[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c >= 7) ? 4'b0001 : 4'b0000, (c == 7) ? 4'b0001 : 4'b0000, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clean_press step %0d: got %b expected %b", c, got, exp);
            end
        end
        raw_in[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c < 7) ? 4'b0001 : 4'b0000, 4'b0000, (c == 7) ? 4'b0001 : 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clean_release step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // Bouncing press on channel 1, a short low glitch, then a clean release
    task automatic test_bounce();
        logic [11:0] got, exp;
        for (int b = 0; b < 4; b++) begin
            raw_in[1] = ((b % 2) == 0);
            step();
            got = {level, press_tick, release_tick};
            n_cmp++;
            if (got !== 12'h000) begin
                n_bad++;
                $display("FAIL bounce_toggle step %0d: got %b expected %b", b, got, 12'h000);
            end
        end
        raw_in[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c >= 7) ? 4'b0010 : 4'b0000, (c == 7) ? 4'b0010 : 4'b0000, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bounce_settle step %0d: got %b expected %b", c, got, exp);
            end
        end
        for (int c = 1; c <= 12; c++) begin
            raw_in[1] = (c > 3);
            step();
            got = {level, press_tick, release_tick};
            exp = {4'b0010, 4'b0000, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bounce_glitch step %0d: got %b expected %b", c, got, exp);
            end
        end
        raw_in[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c < 7) ? 4'b0010 : 4'b0000, 4'b0000, (c == 7) ? 4'b0010 : 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bounce_release step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // Active-low channel 2: driving the pin low is a press
    task automatic test_invert();
        logic [11:0] got, exp;
        raw_in[2] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c >= 7) ? 4'b0100 : 4'b0000, (c == 7) ? 4'b0100 : 4'b0000, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL invert_press step %0d: got %b expected %b", c, got, exp);
            end
        end
        raw_in[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c < 7) ? 4'b0100 : 4'b0000, 4'b0000, (c == 7) ? 4'b0100 : 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL invert_release step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // Reset during a count on channel 3 discards it; count restarts after
    task automatic test_reset_mid_count();
        logic [11:0] got, exp;
        raw_in[3] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            got = {level, press_tick, release_tick};
            n_cmp++;
            if (got !== 12'h000) begin
                n_bad++;
                $display("FAIL midrst_pre step %0d: got %b expected %b", c, got, 12'h000);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {level, press_tick, release_tick};
        n_cmp++;
        if (got !== 12'h000) begin
            n_bad++;
            $display("FAIL midrst_in_reset: got %b expected %b", got, 12'h000);
        end
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c >= 7) ? 4'b1000 : 4'b0000, (c == 7) ? 4'b1000 : 4'b0000, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL midrst_press step %0d: got %b expected %b", c, got, exp);
            end
        end
        raw_in[3] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c < 7) ? 4'b1000 : 4'b0000, 4'b0000, (c == 7) ? 4'b1000 : 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL midrst_release step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // All four channels press and release together
    task automatic test_simultaneous();
        logic [11:0] got, exp;
        raw_in = 4'b1011;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c >= 7) ? 4'hF : 4'h0, (c == 7) ? 4'hF : 4'h0, 4'h0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL simul_press step %0d: got %b expected %b", c, got, exp);
            end
        end
        raw_in = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = {level, press_tick, release_tick};
            exp = {(c < 7) ? 4'hF : 4'h0, 4'h0, (c == 7) ? 4'hF : 4'h0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL simul_release step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // Long hold on channel 0: repeats at T+10, T+13, T+16 only when enabled
    task automatic test_autorepeat();
        logic [11:0] got, exp;
        logic        p;
        raw_in[0] = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (c == 22) raw_in[0] = 1'b0;
            step();
            p   = (c == 7) || (c_AUTOREPEAT && (c == 17 || c == 20 || c == 23));
            got = {level, press_tick, release_tick};
            exp = {(c >= 7 && c < 28) ? 4'b0001 : 4'b0000,
                   {3'b000, p},
                   (c == 28) ? 4'b0001 : 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL autorepeat step %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_invert();
        test_reset_mid_count();
        test_simultaneous();
        test_autorepeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
